vector_sequencer: RTL

Self-checking hardware vector sequencer for unit verification of decode-system blocks (adder, ALU, comparator, buffers, latches, decompressor control). It replaces a fixed set of one-DUT-per-instance harnesses with a single controller that does four things for up to CHANNELS DUT channels. It fetches stimulus/expected/mask triples from an external vector memory. It drives each DUT through a valid/ready handshake. It compares masked results, with a timeout. It keeps per-channel pass/fail statistics readable by the bench or a debug port.

---
 rtl/vector_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/vector_sequencer.sv
// Vector sequencer: fetches stimulus/expected/mask triples, drives each enabled
// DUT channel through a valid/ready handshake and keeps masked-compare statistics.
module vector_sequencer #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 64,
    parameter int CHANNELS = 4,
    parameter int TIMEOUT  = 15,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(CHANNELS)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [CHANNELS-1:0] chan_en_i,
    input  logic [AW:0]         num_vec_i,
    output logic [CW+AW-1:0]    vmem_addr_o,
    input  logic [WIDTH-1:0]    vmem_stim_i,
    input  logic [WIDTH-1:0]    vmem_exp_i,
    input  logic [WIDTH-1:0]    vmem_mask_i,
    output logic [CW-1:0]       dut_sel_o,
    output logic                dut_valid_o,
    output logic [WIDTH-1:0]    dut_stim_o,
    input  logic                dut_ready_i,
    input  logic                res_valid_i,
    input  logic [WIDTH-1:0]    res_data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                fail_o,
    output logic [CW+AW-1:0]    first_fail_addr_o,
    input  logic [CW-1:0]       stat_sel_i,
    output logic [15:0]         stat_pass_o,
    output logic [15:0]         stat_fail_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_DRIVE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [AW:0]         nvec_q, nvec_d;
    logic [CW-1:0]       chan_q, chan_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [WIDTH-1:0]    stim_q, stim_d;
    logic [WIDTH-1:0]    exp_q, exp_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                fail_q, fail_d;
    logic [CW+AW-1:0]    ffa_q, ffa_d;
    logic [15:0]         pass_q [CHANNELS];
    logic [15:0]         pass_d [CHANNELS];
    logic [15:0]         failc_q [CHANNELS];
    logic [15:0]         failc_d [CHANNELS];

    logic                vecDone, vecFail, lastIdx;
    logic [CW:0]         firstHit, nextHit;

    // Returns {found, channel} for the lowest enabled channel strictly above 'above'.
    function automatic logic [CW:0] findEnabled(input logic [CHANNELS-1:0] en, input int above);
        logic [CW:0] r;
        r = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (en[c] && c > above) r = {1'b1, CW'(c)};
        end
        return r;
    endfunction

    assign firstHit = findEnabled(chan_en_i, -1);
    assign nextHit  = findEnabled(en_q, int'(chan_q));
    assign lastIdx  = ({1'b0, idx_q} == (nvec_q - {{AW{1'b0}}, 1'b1}));

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        nvec_d  = nvec_q;
        chan_d  = chan_q;
        idx_d   = idx_q;
        stim_d  = stim_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        tmo_d   = tmo_q;
        fail_d  = fail_q;
        ffa_d   = ffa_q;
        pass_d  = pass_q;
        failc_d = failc_q;
        vecDone = 1'b0;
        vecFail = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    en_d   = chan_en_i;
                    nvec_d = num_vec_i;
                    idx_d  = '0;
                    chan_d = firstHit[CW-1:0];
                    fail_d = 1'b0;
                    ffa_d  = '0;
                    for (int c = 0; c < CHANNELS; c++) begin
                        pass_d[c]  = '0;
                        failc_d[c] = '0;
                    end
                    state_d = (firstHit[CW] && num_vec_i != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                stim_d  = vmem_stim_i;
                exp_d   = vmem_exp_i;
                mask_d  = vmem_mask_i;
                state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (dut_ready_i) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (res_valid_i) begin
                    vecDone = 1'b1;
                    vecFail = |((res_data_i ^ exp_q) & mask_q);
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    vecDone = 1'b1;
                    vecFail = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (vecDone) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (lastIdx) begin
                    idx_d = '0;
                    if (nextHit[CW]) begin
                        chan_d  = nextHit[CW-1:0];
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (vecDone) begin
            if (vecFail) begin
                if (failc_q[chan_q] != 16'hFFFF) failc_d[chan_q] = failc_q[chan_q] + 16'd1;
                if (!fail_q) begin
                    fail_d = 1'b1;
                    ffa_d  = {chan_q, idx_q};
                end
            end else begin
                if (pass_q[chan_q] != 16'hFFFF) pass_d[chan_q] = pass_q[chan_q] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            nvec_q  <= '0;
            chan_q  <= '0;
            idx_q   <= '0;
            stim_q  <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            tmo_q   <= '0;
            fail_q  <= 1'b0;
            ffa_q   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pass_q[c]  <= '0;
                failc_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            nvec_q  <= nvec_d;
            chan_q  <= chan_d;
            idx_q   <= idx_d;
            stim_q  <= stim_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            tmo_q   <= tmo_d;
            fail_q  <= fail_d;
            ffa_q   <= ffa_d;
            pass_q  <= pass_d;
            failc_q <= failc_d;
        end
    end

    assign vmem_addr_o       = {chan_q, idx_q};
    assign dut_sel_o         = chan_q;
    assign dut_valid_o       = (state_q == S_DRIVE);
    assign dut_stim_o        = stim_q;
    assign busy_o            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o            = (state_q == S_DONE);
    assign fail_o            = fail_q;
    assign first_fail_addr_o = ffa_q;
    assign stat_pass_o       = pass_q[stat_sel_i];
    assign stat_fail_o       = failc_q[stat_sel_i];

endmodule
